// File: rtl/pipe_trace_monitor_if.sv
// Signal bundle between the pipelined CPU environment and the trace/end-of-run monitor.
// The monitor attaches through the slave modport; the CPU side uses master.
interface pipe_trace_monitor_if #(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned CNT_W       = 16
);
    localparam int unsigned CW = $clog2(TRACE_DEPTH) + 1;

    logic              start;
    logic              ret_valid;
    logic [31:0]       ret_pc;
    logic [31:0]       ret_inst;
    logic              ret_we;
    logic [4:0]        ret_rd;
    logic [31:0]       ret_wdata;
    logic              tr_valid;
    logic              tr_ready;
    logic [101:0]      tr_data;
    logic [CW-1:0]     tr_count;
    logic              tr_overflow;
    logic [4:0]        reg_sel;
    logic [31:0]       reg_data;
    logic              dump_valid;
    logic [4:0]        dump_idx;
    logic [31:0]       dump_data;
    logic              busy;
    logic              halted;
    logic              timed_out;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output start, ret_valid, ret_pc, ret_inst, ret_we, ret_rd, ret_wdata, tr_ready, reg_data,
        input  tr_valid, tr_data, tr_count, tr_overflow, reg_sel, dump_valid, dump_idx,
               dump_data, busy, halted, timed_out, done, cycle_cnt
    );

    modport slave (
        input  start, ret_valid, ret_pc, ret_inst, ret_we, ret_rd, ret_wdata, tr_ready, reg_data,
        output tr_valid, tr_data, tr_count, tr_overflow, reg_sel, dump_valid, dump_idx,
               dump_data, busy, halted, timed_out, done, cycle_cnt
    );
endinterface

// File: rtl/pipe_trace_monitor.sv
// Retirement trace FIFO plus halt/timeout detection and register-file dump sequencer.
// The interface TRACE_DEPTH/CNT_W must match the module parameters.
module pipe_trace_monitor #(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter logic [31:0] HALT_PC     = 32'h0000_0128,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NREG        = 32
) (
    input logic                clk,
    input logic                rstn,
    pipe_trace_monitor_if.slave bus
);
    localparam int unsigned AW = $clog2(TRACE_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDump, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    logic [101:0]      mem [TRACE_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q, halted_q, timed_out_q, done_q, dump_valid_q;
    logic [4:0]        dump_idx_q, ptr_q;
    logic [31:0]       dump_data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic arm, full, pop, in_run, push_req, push, drop, hit_halt, hit_to, last;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        arm      = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
        full     = (count_q == CW'(TRACE_DEPTH));
        pop      = (count_q != '0) && bus.tr_ready;
        in_run   = (state_q == StRun);
        push_req = in_run && bus.ret_valid;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        hit_halt = push_req && (bus.ret_pc == HALT_PC);
        hit_to   = in_run && (cnt_q == CNT_W'(TIMEOUT - 1)) && !hit_halt;
        last     = (ptr_q == 5'(NREG - 1));
        state_d  = state_q;
        case (state_q)
            StIdle, StDone: if (bus.start) state_d = StRun;
            StRun:          if (hit_halt || hit_to) state_d = StDump;
            StDump:         if (last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            done_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (arm) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                overflow_q   <= 1'b0;
                halted_q     <= 1'b0;
                timed_out_q  <= 1'b0;
                done_q       <= 1'b0;
                dump_valid_q <= 1'b0;
                dump_idx_q   <= '0;
                dump_data_q  <= '0;
                ptr_q        <= '0;
                cnt_q        <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
                if (drop)     overflow_q  <= 1'b1;
                if (hit_halt) halted_q    <= 1'b1;
                if (hit_to)   timed_out_q <= 1'b1;
                // The counter freezes on the exit edge so it reports the last RUN cycle.
                if (in_run && (state_d == StRun)) cnt_q <= cnt_q + 1'b1;
                if (state_q == StDump) begin
                    dump_valid_q <= 1'b1;
                    dump_idx_q   <= ptr_q;
                    dump_data_q  <= (ptr_q == '0) ? 32'h0 : bus.reg_data;
                    ptr_q        <= ptr_q + 1'b1;
                end else begin
                    dump_valid_q <= 1'b0;
                end
                if (state_q == StDone) done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bus.ret_we, bus.ret_rd, bus.ret_pc, bus.ret_inst,
                                    bus.ret_wdata};
    end

    assign bus.tr_valid    = (count_q != '0);
    assign bus.tr_data     = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign bus.tr_count    = count_q;
    assign bus.tr_overflow = overflow_q;
    assign bus.reg_sel     = (state_q == StDump) ? ptr_q : 5'd0;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_idx    = dump_idx_q;
    assign bus.dump_data   = dump_data_q;
    assign bus.busy        = (state_q == StRun) || (state_q == StDump);
    assign bus.halted      = halted_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.done        = done_q;
    assign bus.cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Randomized bench for pipe_trace_monitor with a queue-based FIFO model and a
// timing-rule model of the run/dump/done sequence.
module tb_pipe_trace_monitor;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned NREG    = 32;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] HALT    = 32'h0000_0128;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pipe_trace_monitor_if #(.TRACE_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipe_trace_monitor #(
        .TRACE_DEPTH(DEPTH), .HALT_PC(HALT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .NREG(NREG)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    logic [31:0] regs [32];
    assign bus.reg_data = regs[bus.reg_sel];

    int n_checks = 0;
    int n_errors = 0;

    // Model: FIFO contents, sticky flags, RUN cycle count, edges since end of RUN (-1: none).
    logic [101:0] mq[$];
    logic [101:0] dut_popped[$];
    bit m_run, m_ovf, m_halted, m_timed;
    int m_cnt;
    int m_since = -1;

    task automatic idle_inputs();
        bus.start = 1'b0; bus.ret_valid = 1'b0; bus.ret_pc = '0; bus.ret_inst = '0;
        bus.ret_we = 1'b0; bus.ret_rd = '0; bus.ret_wdata = '0; bus.tr_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = $urandom & 32'hffff_fffc;
        if (pc == HALT) pc = pc + 32'd4;
        return pc;
    endfunction

    task automatic set_ret(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                           input logic [31:0] wdata);
        bus.ret_valid = 1'b1; bus.ret_pc = pc; bus.ret_inst = $urandom;
        bus.ret_we = we; bus.ret_rd = rd; bus.ret_wdata = wdata;
        if (we && rd != 5'd0) regs[rd] = wdata;
    endtask

    task automatic step();
        logic [101:0] exp_head, rec;
        logic [31:0]  exp_data;
        bit dumping, arm, pop, push_req, halt_now, to_now, exp_dv, exp_busy, exp_done;
        int exp_sel;
        exp_head = (mq.size() != 0) ? mq[0] : '0;
        n_checks++;
        if (bus.tr_data !== exp_head) begin
            n_errors++;
            $display("FAIL tr_data: got %h expected %h", bus.tr_data, exp_head);
        end
        if (bus.tr_valid && bus.tr_ready) dut_popped.push_back(bus.tr_data);
        dumping  = (m_since >= 0) && (m_since < int'(NREG));
        arm      = bus.start && !m_run && !dumping;
        pop      = (mq.size() != 0) && bus.tr_ready;
        push_req = m_run && bus.ret_valid;
        rec      = {bus.ret_we, bus.ret_rd, bus.ret_pc, bus.ret_inst, bus.ret_wdata};
        if (arm) begin
            mq.delete(); m_ovf = 0; m_halted = 0; m_timed = 0; m_cnt = 0; m_run = 1;
            m_since = -1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push_req) begin
                if (mq.size() < DEPTH) mq.push_back(rec);
                else m_ovf = 1;
            end
            halt_now = push_req && (bus.ret_pc == HALT);
            to_now   = m_run && (m_cnt == int'(TIMEOUT) - 1) && !halt_now;
            if (halt_now) m_halted = 1;
            if (to_now)   m_timed = 1;
            if (halt_now || to_now) begin
                m_run = 0; m_since = 0;
            end else if (m_run) m_cnt++;
            else if (m_since >= 0) m_since++;
        end
        @(posedge clk); #1;
        exp_dv   = (m_since >= 1) && (m_since <= int'(NREG));
        exp_busy = m_run || ((m_since >= 0) && (m_since < int'(NREG)));
        exp_done = (m_since > int'(NREG));
        exp_sel  = ((m_since >= 0) && (m_since < int'(NREG))) ? m_since : 0;
        n_checks++;
        if (bus.tr_count !== CW'(mq.size()) || bus.tr_valid !== (mq.size() != 0)) begin
            n_errors++;
            $display("FAIL tr_count: got %0d/%b expected %0d", bus.tr_count, bus.tr_valid,
                     mq.size());
        end
        n_checks++;
        if (bus.tr_overflow !== m_ovf) begin
            n_errors++; $display("FAIL tr_overflow: got %b expected %b", bus.tr_overflow, m_ovf);
        end
        n_checks++;
        if ({bus.halted, bus.timed_out} !== {m_halted, m_timed}) begin
            n_errors++;
            $display("FAIL halted/timed_out: got %b%b expected %b%b", bus.halted,
                     bus.timed_out, m_halted, m_timed);
        end
        n_checks++;
        if ({bus.busy, bus.done, bus.dump_valid} !== {exp_busy, exp_done, exp_dv}) begin
            n_errors++;
            $display("FAIL busy/done/dump_valid: got %b%b%b expected %b%b%b", bus.busy,
                     bus.done, bus.dump_valid, exp_busy, exp_done, exp_dv);
        end
        n_checks++;
        if (bus.cycle_cnt !== CNT_W'(m_cnt) || bus.reg_sel !== 5'(exp_sel)) begin
            n_errors++;
            $display("FAIL cycle_cnt/reg_sel: got %0d/%0d expected %0d/%0d", bus.cycle_cnt,
                     bus.reg_sel, m_cnt, exp_sel);
        end
        if (exp_dv) begin
            exp_data = (m_since == 1) ? 32'h0 : regs[m_since - 1];
            n_checks++;
            if (bus.dump_idx !== 5'(m_since - 1) || bus.dump_data !== exp_data) begin
                n_errors++;
                $display("FAIL dump: got idx %0d data %h expected idx %0d data %h",
                         bus.dump_idx, bus.dump_data, m_since - 1, exp_data);
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        n_checks++;
        if ({bus.tr_valid, bus.tr_data, bus.tr_count, bus.tr_overflow, bus.reg_sel,
             bus.dump_valid, bus.dump_idx, bus.dump_data, bus.busy, bus.halted,
             bus.timed_out, bus.done, bus.cycle_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b dv=%b idx=%0d cnt=%0d count=%0d, required all 0",
                     bus.busy, bus.dump_valid, bus.dump_idx, bus.cycle_cnt, bus.tr_count);
        end
        mq.delete(); m_run = 0; m_ovf = 0; m_halted = 0; m_timed = 0; m_cnt = 0; m_since = -1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic arm_run();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        dut_popped.delete();
    endtask

    task automatic run_to_done();
        int k = 0;
        bus.ret_valid = 1'b0;
        while (bus.done !== 1'b1 && k < 100) begin
            step(); k++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || m_since != int'(NREG) + 1) begin
            n_errors++;
            $display("FAIL done_latency: got done=%b after %0d cycles, required 1 after %0d",
                     bus.done, m_since, NREG + 1);
        end
    endtask

    task automatic finish_run();
        bus.tr_ready = 1'b1;
        set_ret(HALT, 1'b0, 5'd0, 32'h0);
        step();
        run_to_done();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step();
    endtask

    task automatic test_halt();
        logic [4:0] rd;
        arm_run();
        bus.tr_ready = 1'b1;
        for (int i = 0; i < 75; i++) begin
            bus.ret_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            rd = 5'((i % 31) + 1);
            set_ret(32'(i * 4), 1'b1, rd, $urandom);
            step();
        end
        n_checks++;
        if (bus.halted !== 1'b1 || bus.timed_out !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_flags: got halted=%b timed_out=%b required 1/0", bus.halted,
                     bus.timed_out);
        end
        run_to_done();
        n_checks++;
        if (dut_popped.size() != 75 || bus.tr_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_records: got %0d records ovf=%b required 75 ovf=0",
                     dut_popped.size(), bus.tr_overflow);
        end else begin
            n_checks++;
            if (dut_popped[74][95:64] !== HALT) begin
                n_errors++;
                $display("FAIL halt_last_pc: got %h required %h", dut_popped[74][95:64], HALT);
            end
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        arm_run();
        while (m_run && k < 1100) begin
            bus.tr_ready = 1'($urandom);
            step(); k++;
        end
        n_checks++;
        if (bus.timed_out !== 1'b1 || bus.halted !== 1'b0 || bus.cycle_cnt !== CNT_W'(999) ||
            k != int'(TIMEOUT)) begin
            n_errors++;
            $display("FAIL timeout: got to=%b h=%b cnt=%0d after %0d cycles, required 1/0/999/1000",
                     bus.timed_out, bus.halted, bus.cycle_cnt, k);
        end
        run_to_done();
    endtask

    task automatic test_overflow();
        logic [101:0] first[$];
        arm_run();
        bus.tr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ret(rand_pc(), 1'($urandom), 5'($urandom), $urandom);
            if (i < 4) first.push_back({bus.ret_we, bus.ret_rd, bus.ret_pc, bus.ret_inst,
                                        bus.ret_wdata});
            step();
        end
        bus.ret_valid = 1'b0;
        n_checks++;
        if (bus.tr_count !== CW'(4) || bus.tr_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: got count=%0d ovf=%b required 4/1", bus.tr_count,
                     bus.tr_overflow);
        end
        bus.tr_ready = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut_popped.size() <= i || dut_popped[i] !== first[i]) begin
                n_errors++;
                $display("FAIL overflow_drain[%0d]: got %h required %h", i,
                         (dut_popped.size() > i) ? dut_popped[i] : '0, first[i]);
            end
        end
        finish_run();
    endtask

    task automatic test_full_push_pop();
        logic [101:0] newest;
        arm_run();
        bus.tr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ret(rand_pc(), 1'b1, 5'($urandom), $urandom);
            step();
        end
        bus.tr_ready = 1'b1;
        set_ret(rand_pc(), 1'b1, 5'($urandom), $urandom);
        newest = {bus.ret_we, bus.ret_rd, bus.ret_pc, bus.ret_inst, bus.ret_wdata};
        step();
        bus.ret_valid = 1'b0;
        n_checks++;
        if (bus.tr_count !== CW'(4) || bus.tr_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b required 4/0", bus.tr_count,
                     bus.tr_overflow);
        end
        dut_popped.delete();
        repeat (4) step();
        n_checks++;
        if (dut_popped.size() != 4 || dut_popped[3] !== newest) begin
            n_errors++;
            $display("FAIL full_push_pop_last: got %0d pops last %h required %h",
                     dut_popped.size(), (dut_popped.size() != 0) ? dut_popped[$] : '0, newest);
        end
        finish_run();
    endtask

    task automatic test_random();
        arm_run();
        for (int i = 0; i < 150; i++) begin
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.tr_ready = 1'($urandom);
            if ($urandom_range(0, 9) < 6) set_ret(rand_pc(), 1'($urandom), 5'($urandom), $urandom);
            else bus.ret_valid = 1'b0;
            step();
        end
        bus.start = 1'b0;
        finish_run();
    endtask

    task automatic test_simultaneous();
        int k = 0;
        arm_run();
        bus.tr_ready = 1'b1;
        while (m_cnt != int'(TIMEOUT) - 1 && k < 1100) begin
            step(); k++;
        end
        set_ret(HALT, 1'b1, 5'd3, $urandom);
        step();
        n_checks++;
        if (bus.halted !== 1'b1 || bus.timed_out !== 1'b0 || bus.cycle_cnt !== CNT_W'(999)) begin
            n_errors++;
            $display("FAIL simultaneous_end: got h=%b to=%b cnt=%0d required 1/0/999",
                     bus.halted, bus.timed_out, bus.cycle_cnt);
        end
        run_to_done();
    endtask

    task automatic test_reset_rearm();
        int k = 0;
        arm_run();
        bus.tr_ready = 1'b0;
        set_ret(rand_pc(), 1'b1, 5'd7, $urandom);
        step();
        set_ret(HALT, 1'b1, 5'd9, $urandom);
        step();
        bus.ret_valid = 1'b0;
        while (m_since < 11 && k < 100) begin
            step(); k++;
        end
        n_checks++;
        if (bus.dump_valid !== 1'b1 || bus.dump_idx !== 5'd10) begin
            n_errors++;
            $display("FAIL rearm_dump_idx: got dv=%b idx=%0d required 1/10", bus.dump_valid,
                     bus.dump_idx);
        end
        do_reset();
        repeat (2) step();
        arm_run();
        for (int i = 0; i < 40; i++) begin
            bus.start    = 1'($urandom);
            bus.tr_ready = 1'($urandom);
            if ($urandom_range(0, 1) == 0) set_ret(rand_pc(), 1'b1, 5'($urandom), $urandom);
            else bus.ret_valid = 1'b0;
            step();
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.cycle_cnt !== CNT_W'(40)) begin
            n_errors++;
            $display("FAIL start_ignored: got busy=%b cnt=%0d required 1/40", bus.busy,
                     bus.cycle_cnt);
        end
        bus.start = 1'b0;
        finish_run();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hdead_beef;
        idle_inputs();
        test_reset();
        test_halt();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_simultaneous();
        test_reset_rearm();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_trace_monitor.md
# pipe_trace_monitor

Synthesizable retirement-trace and end-of-run monitor for the pipelined CPU. It watches the MEM/WB retirement stream and buffers retired-instruction records in a drainable FIFO. It detects a configurable halt PC or a cycle timeout, then sequences a full register-file dump through the CPU's `reg_sel`/`reg_data` debug port. It sits beside the CPU in the top-level comp and replaces ad-hoc simulation-only monitors with a block usable on FPGA.

## Interface
- `TRACE_DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `HALT_PC`, 32'h0000_0128: retirement PC that ends the run.
- `TIMEOUT`, 1000: RUN-state cycle budget; ≥1, < 2^CNT_W.
- `CNT_W`, 16: cycle-counter width.
- `NREG`, 32: registers dumped, 1..32.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle arm pulse.
- `ret_valid` in 1: MEM/WB valid retirement this cycle.
- `ret_pc` in 32, `ret_inst` in 32: PC and instruction of the retiring op.
- `ret_we` in 1, `ret_rd` in 5, `ret_wdata` in 32: register write-back info.
- `tr_valid` out 1, `tr_ready` in 1: trace FIFO output handshake.
- `tr_data` out 102: head record {we, rd, pc, inst, wdata}, MSB first.
- `tr_count` out $clog2(TRACE_DEPTH)+1: occupancy.
- `tr_overflow` out 1: sticky; a record was dropped.
- `reg_sel` out 5, `reg_data` in 32: CPU debug read port (combinational read).
- `dump_valid` out 1, `dump_idx` out 5, `dump_data` out 32: dump stream.
- `busy` out 1, `halted` out 1, `timed_out` out 1, `done` out 1: status.
- `cycle_cnt` out CNT_W: RUN cycles elapsed.

## Operation
- States: IDLE, RUN, DUMP, DONE. Reset enters IDLE.
- IDLE/DONE with `start`=1: go to RUN. Clear cycle_cnt, FIFO, tr_overflow, halted, timed_out, done, and the dump pointer. `start` is ignored in RUN/DUMP.
- RUN: cycle_cnt increments every cycle. Each `ret_valid` pushes one record.
  - FIFO full with no pop that cycle: drop the record and set tr_overflow. The oldest record is never overwritten.
- RUN, `ret_valid` with `ret_pc`==HALT_PC: push that record, set halted, go to DUMP.
- RUN, cycle_cnt==TIMEOUT-1 with no halt: set timed_out, go to DUMP. Halt wins if both occur in the same cycle.
- DUMP: `reg_sel`=ptr. Each cycle the block registers dump_idx<=ptr and dump_data<=(ptr==0 ? 0 : reg_data), then ptr increments. After ptr==NREG-1 is issued, go to DONE.
  - `ret_valid` is ignored in DUMP and DONE.
- DONE: `done`=1. Status flags hold until next start.
- FIFO: `tr_valid`=(tr_count!=0). A pop occurs on tr_valid&tr_ready, in any state. Push and pop in the same cycle:
  - count unchanged;
  - when full, the push is accepted.
- Pointers wrap modulo TRACE_DEPTH. `tr_data` shows the head entry and is undefined-safe (0) when empty.
- `busy`=RUN or DUMP. `reg_sel` holds 0 outside DUMP.

## Timing
- Reset (async assert, sync deassert inside the block): all outputs 0. State is IDLE, FIFO is empty, flags are cleared.
- start→RUN: 1 cycle. cycle_cnt reads 0 in the first RUN cycle.
- ret_valid→tr_valid: 1 cycle, when the FIFO was empty.
- Halt retirement at edge N: halted=1 and state DUMP after edge N.
- Dump stream:
  - dump_valid goes high 1 cycle after entering DUMP and stays high for exactly NREG consecutive cycles, with dump_idx 0..NREG-1 in order;
  - dump_valid falls in the same cycle done rises.
- Timeout: timed_out rises after the RUN cycle in which cycle_cnt==TIMEOUT-1, i.e. exactly TIMEOUT RUN cycles.
- Reset mid-operation: immediate return to IDLE. Partial dump and FIFO contents are discarded.

## Test plan
- Halt: start, then retire PCs 0x0,0x4,…,0x128 with sequential writes. Require:
  - halted=1, timed_out=0;
  - 75 trace records, last pc=0x128;
  - dump_idx 0..31, dump_data[0]=0, values matching the model register file;
  - done 33 cycles after halt.
- Timeout: start, ret_valid never asserted, TIMEOUT=1000. Require timed_out=1 after 1000 RUN cycles, cycle_cnt=999, halted=0, followed by a full dump.
- Overflow: TRACE_DEPTH=4, tr_ready=0, six retirements. Require:
  - tr_count=4 and tr_overflow=1;
  - draining yields the first four records in order.
- Full push+pop: with the FIFO full, assert tr_ready=1 and ret_valid=1 together. Require tr_count stays 4, tr_overflow stays 0, and the new record appears last.
- Simultaneous end: a halt PC retires in the same cycle as TIMEOUT-1. Require halted=1 and timed_out=0.
- Reset/rearm: deassert rstn at dump_idx=10. Require all outputs 0 and state IDLE. Then start again: require the run completes normally and `start` pulses during RUN are ignored.
